// File: rtl/ram_bus_arbiter.sv
// Two-requester arbiter sharing one 32-bit memory bus between instruction fetch and data access.
// Grants alternate under contention; a flush drops the result of an in-flight fetch.
module ram_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ready_o,
    output logic [31:0] if_data_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_data_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {IDLE, IF_BUS, MEM_BUS, DONE} state_t;

    state_t state, state_next;
    logic   last_grant_mem;
    logic   cancel;
    logic   grant_if, grant_mem;
    logic   if_req;

    assign bus_stb_o = bus_cyc_o;
    assign if_req    = if_ce_i && !flush;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_mem  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_ce_i && (!if_req || !last_grant_mem)) begin
                    state_next = MEM_BUS;
                    grant_mem  = 1'b1;
                end else if (if_req) begin
                    state_next = IF_BUS;
                    grant_if   = 1'b1;
                end
            end
            IF_BUS, MEM_BUS: if (bus_ack_i) state_next = DONE;
            DONE:            state_next = IDLE;
            default:         state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant_mem <= 1'b0;
            cancel         <= 1'b0;
            bus_cyc_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_sel_o      <= 4'b0;
            bus_addr_o     <= 32'b0;
            bus_data_o     <= 32'b0;
            if_ready_o     <= 1'b0;
            if_data_o      <= 32'b0;
            mem_ready_o    <= 1'b0;
            mem_data_o     <= 32'b0;
        end else begin
            state       <= state_next;
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;

            if (grant_if) begin
                bus_cyc_o      <= 1'b1;
                bus_we_o       <= 1'b0;
                bus_sel_o      <= 4'b1111;
                bus_addr_o     <= if_addr_i;
                bus_data_o     <= 32'b0;
                last_grant_mem <= 1'b0;
                cancel         <= 1'b0;
            end

            if (grant_mem) begin
                bus_cyc_o      <= 1'b1;
                bus_we_o       <= mem_we_i;
                bus_sel_o      <= mem_sel_i;
                bus_addr_o     <= mem_addr_i;
                bus_data_o     <= mem_data_i;
                last_grant_mem <= 1'b1;
            end

            // A flush coinciding with the ack still suppresses delivery of the fetch.
            if (state == IF_BUS) begin
                if (bus_ack_i) begin
                    bus_cyc_o <= 1'b0;
                    cancel    <= 1'b0;
                    if (!(cancel || flush)) begin
                        if_ready_o <= 1'b1;
                        if_data_o  <= bus_data_i;
                    end
                end else if (flush) begin
                    cancel <= 1'b1;
                end
            end

            if (state == MEM_BUS && bus_ack_i) begin
                bus_cyc_o   <= 1'b0;
                mem_ready_o <= 1'b1;
                if (!bus_we_o) mem_data_o <= bus_data_i;
            end
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed + randomized bench for ram_bus_arbiter; a transaction-level model predicts grant
// order, bus fields, ready pulses and returned data.
module tb_ram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        if_ce_i, mem_ce_i, mem_we_i, bus_ack_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_data_i, bus_data_i;
    logic [3:0]  mem_sel_i;
    logic        if_ready_o, mem_ready_o, bus_cyc_o, bus_stb_o, bus_we_o;
    logic [31:0] if_data_o, mem_data_o, bus_addr_o, bus_data_o;
    logic [3:0]  bus_sel_o;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model state
    logic        last_mem;
    logic [31:0] exp_if_data, exp_mem_data;

    always #5 clk = ~clk;

    ram_bus_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o), .if_data_o(if_data_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_ready_o(mem_ready_o), .mem_data_o(mem_data_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"},      {31'b0, bus_cyc_o},   32'h0);
        check({tag, "_stb"},      {31'b0, bus_stb_o},   32'h0);
        check({tag, "_we"},       {31'b0, bus_we_o},    32'h0);
        check({tag, "_sel"},      {28'b0, bus_sel_o},   32'h0);
        check({tag, "_addr"},     bus_addr_o,           32'h0);
        check({tag, "_bdata"},    bus_data_o,           32'h0);
        check({tag, "_if_rdy"},   {31'b0, if_ready_o},  32'h0);
        check({tag, "_if_data"},  if_data_o,            32'h0);
        check({tag, "_mem_rdy"},  {31'b0, mem_ready_o}, 32'h0);
        check({tag, "_mem_data"}, mem_data_o,           32'h0);
    endtask

    // Called at a negedge with the request already driven; plays the bus slave for one transfer.
    task automatic serve(input string tag, input logic is_mem, input logic [31:0] addr,
                         input logic we, input logic [3:0] sel, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rdata, input int flush_at,
                         input int exp_latency);
        int  lat = 0;
        logic cancelled;
        cancelled = !is_mem && flush_at >= 0 && flush_at <= waits;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_cyc_o && lat < 20);
        check({tag, "_cyc_start"}, {31'b0, bus_cyc_o}, 32'h1);
        if (exp_latency > 0) check({tag, "_latency"}, lat, exp_latency);
        if (!bus_cyc_o) return;
        for (int i = 0; i <= waits; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_cyc"},  {31'b0, bus_cyc_o}, 32'h1);
            check({tag, "_stb"},  {31'b0, bus_stb_o}, 32'h1);
            check({tag, "_addr"}, bus_addr_o, addr);
            check({tag, "_we"},   {31'b0, bus_we_o}, {31'b0, we});
            check({tag, "_sel"},  {28'b0, bus_sel_o}, {28'b0, sel});
            if (is_mem) check({tag, "_wdata"}, bus_data_o, wdata);
            flush      = (i == flush_at);
            bus_ack_i  = (i == waits);
            bus_data_i = (i == waits) ? rdata : $urandom;
        end
        @(negedge clk);
        bus_ack_i = 1'b0;
        flush     = 1'b0;
        if (!is_mem && !cancelled) exp_if_data = rdata;
        if (is_mem && !we) exp_mem_data = rdata;
        last_mem = is_mem;
        check({tag, "_cyc_drop"}, {31'b0, bus_cyc_o},   32'h0);
        check({tag, "_if_rdy"},   {31'b0, if_ready_o},  {31'b0, !is_mem && !cancelled});
        check({tag, "_mem_rdy"},  {31'b0, mem_ready_o}, {31'b0, is_mem});
        check({tag, "_if_data"},  if_data_o,  exp_if_data);
        check({tag, "_mem_data"}, mem_data_o, exp_mem_data);
        @(negedge clk);
        check({tag, "_if_rdy_end"},  {31'b0, if_ready_o},  32'h0);
        check({tag, "_mem_rdy_end"}, {31'b0, mem_ready_o}, 32'h0);
        check({tag, "_no_regrant"},  {31'b0, bus_cyc_o},   32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        r_if, r_mem, r_we, pick_mem;
        logic [3:0]  r_sel;
        logic [31:0] r_ia, r_ma, r_wd, r_rd;
        int          r_w;

        rst = 1'b1; flush = 1'b0; if_ce_i = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
        mem_sel_i = 4'h0; if_addr_i = 32'h0; mem_addr_i = 32'h0; mem_data_i = 32'h0;
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        last_mem = 1'b0; exp_if_data = 32'h0; exp_mem_data = 32'h0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Contention from reset: MEM, IF, MEM with both requests held
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0100;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h0000_0080; mem_data_i = 32'hDEAD_BEEF;
        serve("cont_mem1", 1'b1, 32'h80, 1'b1, 4'b0011, 32'hDEAD_BEEF, 0, $urandom, -1, 1);
        serve("cont_if",   1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 0, 32'h0C00_0001, -1, 1);
        serve("cont_mem2", 1'b1, 32'h80, 1'b1, 4'b0011, 32'hDEAD_BEEF, 0, $urandom, -1, 1);
        if_ce_i = 1'b0; mem_ce_i = 1'b0;
        @(negedge clk);
        check("idle_no_req", {31'b0, bus_cyc_o}, 32'h0);

        // Single fetch
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
        serve("fetch", 1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 0, 32'h2402_0005, -1, 1);
        if_ce_i = 1'b0;

        // Wait states on a MEM read
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111;
        mem_addr_i = 32'h0000_2000; mem_data_i = $urandom;
        serve("wait5", 1'b1, 32'h2000, 1'b0, 4'hF, mem_data_i, 5, 32'hCAFE_F00D, -1, 1);

        // Flush in IDLE with both requesting: IF would win but is blocked, MEM goes
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0200; flush = 1'b1;
        mem_addr_i = 32'h0000_2004;
        serve("flush_idle_mem", 1'b1, 32'h2004, 1'b0, 4'hF, mem_data_i, 0, $urandom, -1, 1);
        mem_ce_i = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_block", {31'b0, bus_cyc_o}, 32'h0);
        flush = 1'b0;
        serve("flush_idle_if", 1'b0, 32'h200, 1'b0, 4'hF, 32'h0, 0, $urandom, -1, 1);

        // Flush during fetch, then a held fetch is re-accepted after DONE
        if_addr_i = 32'h0000_0300;
        serve("flush_bus", 1'b0, 32'h300, 1'b0, 4'hF, 32'h0, 3, 32'h1111_1111, 1, 1);
        if_addr_i = 32'h0000_0304;
        serve("flush_ack", 1'b0, 32'h304, 1'b0, 4'hF, 32'h0, 0, 32'h2222_2222, 0, 1);
        if_addr_i = 32'h0000_0308;
        serve("after_flush", 1'b0, 32'h308, 1'b0, 4'hF, 32'h0, 0, $urandom, -1, 1);
        if_ce_i = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            r_if = 1'($urandom); r_mem = 1'($urandom);
            if (!r_if && !r_mem) r_if = 1'b1;
            r_we = 1'($urandom); r_sel = 4'($urandom);
            r_ia = $urandom & 32'hFFFF_FFFC; r_ma = $urandom & 32'hFFFF_FFFC;
            r_wd = $urandom; r_rd = $urandom; r_w = $urandom_range(0, 3);
            if_ce_i = r_if; if_addr_i = r_ia;
            mem_ce_i = r_mem; mem_we_i = r_we; mem_sel_i = r_sel; mem_addr_i = r_ma; mem_data_i = r_wd;
            pick_mem = r_mem && (!r_if || !last_mem);
            if (pick_mem) serve("rnd_mem", 1'b1, r_ma, r_we, r_sel, r_wd, r_w, r_rd, -1, 1);
            else          serve("rnd_if",  1'b0, r_ia, 1'b0, 4'hF, 32'h0, r_w, r_rd, -1, 1);
        end
        if_ce_i = 1'b0; mem_ce_i = 1'b0;
        @(negedge clk);

        // Reset in the middle of a MEM access; a late ack must be ignored
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b0101; mem_addr_i = 32'h0000_4000;
        @(negedge clk);
        check("rst_mid_cyc_before", {31'b0, bus_cyc_o}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0; mem_ce_i = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'h5555_AAAA;
        @(negedge clk);
        bus_ack_i = 1'b0;
        check("late_ack_mem_rdy", {31'b0, mem_ready_o}, 32'h0);
        check("late_ack_cyc",     {31'b0, bus_cyc_o},   32'h0);
        check("late_ack_data",    mem_data_o,           32'h0);
        last_mem = 1'b0; exp_if_data = 32'h0; exp_mem_data = 32'h0;

        // last_grant is back to IF after reset: MEM wins again
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0040;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0044;
        serve("post_rst_mem", 1'b1, 32'h44, 1'b0, 4'hF, mem_data_i, 1, $urandom, -1, 1);
        mem_ce_i = 1'b0;
        serve("post_rst_if", 1'b0, 32'h40, 1'b0, 4'hF, 32'h0, 0, $urandom, -1, 1);
        if_ce_i = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Shares the single 32-bit memory bus between instruction fetch (PC stage) and data access (MEM stage). Each requester holds a chip-enable plus address (and write controls for MEM) until the arbiter returns a one-cycle ready pulse with read data. The requester's stall request is derived from the inverse of that ready. Grants alternate under contention so fetch is never starved, and a pipeline flush discards an in-flight fetch result without disturbing the bus.

## Interface
Parameters:
- none (data and address width fixed at 32)

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; cancels delivery of any pending or in-flight fetch
- if_ce_i  in  1  fetch request, held until if_ready_o
- if_addr_i  in  32  fetch address
- if_ready_o  out  1  one-cycle pulse: fetch complete, if_data_o valid
- if_data_o  out  32  fetched instruction word
- mem_ce_i  in  1  data request, held until mem_ready_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_sel_i  in  4  byte lane enables
- mem_addr_i  in  32  data address
- mem_data_i  in  32  write data
- mem_ready_o  out  1  one-cycle pulse: data access complete
- mem_data_o  out  32  read data; valid with mem_ready_o on reads
- bus_cyc_o  out  1  bus cycle active
- bus_stb_o  out  1  bus strobe; identical to bus_cyc_o
- bus_we_o  out  1  bus write enable
- bus_sel_o  out  4  bus byte lanes; 4'b1111 for fetch
- bus_addr_o  out  32  bus address
- bus_data_o  out  32  bus write data
- bus_data_i  in  32  bus read data, sampled on bus_ack_i
- bus_ack_i  in  1  bus acknowledge; one cycle per transfer

## Operation
- States: IDLE, IF_BUS, MEM_BUS, DONE.
- IDLE arbitration:
  - Only mem_ce_i set: MEM_BUS.
  - Only if_ce_i set (and flush low): IF_BUS.
  - Both set: the requester not served last wins; last_grant resets to IF, so MEM wins the first contention.
  - Neither set: stay in IDLE.
- Entering a BUS state:
  - Register addr, we and sel (fetch: we=0, sel=4'b1111) and data into the bus outputs.
  - Raise bus_cyc_o and bus_stb_o, and update last_grant.
- BUS state, bus_ack_i=1:
  - Drop cyc/stb, capture bus_data_i into the requester's data register, go to DONE.
  - Pulse the matching ready, except a fetch with cancel set (see below).
  - mem_data_o is unchanged on writes.
- BUS state, no ack: hold every bus output stable; there is no timeout.
- DONE lasts exactly one cycle; ready is high and new requests are ignored, then IDLE. This keeps a still-held ce from being re-granted.
- Flush and fetch:
  - flush in IF_BUS sets cancel. The bus cycle runs to ack, then if_ready_o stays low, if_data_o is unchanged, and the state passes through DONE.
  - flush in IDLE blocks an IF grant that cycle; MEM may still be granted.
  - flush never affects a MEM access.
- Reset values: state=IDLE, last_grant=IF, cancel=0, every output 0 (cyc, stb, we, sel, addr, data, ready, data outputs).
- Reset in mid-transaction: all of the above on the next edge, including dropping bus_cyc_o immediately. A late bus_ack_i is then ignored in IDLE.

## Timing
- Request seen in IDLE at edge N; bus_cyc_o high from N+1.
- With ack in cycle N+1+w (w ≥ 0 wait states), ready is high in cycle N+2+w only.
- Minimum 3 cycles per access; back-to-back accesses run at 3 cycles each.
- Ready is a registered single-cycle pulse. Requesters drop or change ce in the cycle after ready.
- bus_ack_i outside a BUS state is ignored.

## Test plan
- Single fetch:
  - Stimulus: if_ce_i=1, addr 0x00000010, ack after 0 waits, bus_data_i=0x24020005.
  - Response: bus_addr_o=0x10 and sel=4'hF in cycle 1; if_ready_o high with 0x24020005 in cycle 2, for exactly 1 cycle.
- Contention:
  - Stimulus: if_ce_i and mem_ce_i both high from reset, with a MEM write to 0x80 of 0xDEADBEEF, sel 4'b0011.
  - Response: MEM is served first (bus_we_o=1, sel 0011), then IF. Both held continuously, grants alternate MEM/IF/MEM.
- Wait states: ack delayed 5 cycles → bus outputs stable for 6 cycles, ready 1 cycle after ack, 8 cycles total.
- Flush during fetch:
  - Stimulus: flush pulse in IF_BUS; ack later with 0x11111111.
  - Response: if_ready_o never rises, if_data_o keeps its old value, next fetch is accepted after DONE.
- Reset mid-access:
  - Stimulus: rst during MEM_BUS.
  - Response: bus_cyc_o=0 next cycle, all outputs 0; an ack that follows produces no ready.
- Stale ce: ce held through the DONE cycle → only one bus cycle and one ready per request.
